// File: rtl/jzjpcc_fetch_decode_buffer.sv
// jzjpcc_fetch_decode_buffer
//   Small FIFO that sits between the fetch stage (PC + instruction SRAM) and decode.
//   Each fetch cycle it accepts one {pc, instruction} pair and presents the oldest
//   queued pair to decode. It holds the PC back when full and drops everything on flush.
//
// Ports
//   clock              in   1              system clock, all state on posedge
//   reset              in   1              synchronous, active-high
//   fetchValid         in   1              fetch pair valid this cycle
//   currentPC_fetch    in   [PC_MAX_B:2]   PC of instruction_fetch
//   instruction_fetch  in   32             SRAM read data for currentPC_fetch
//   stall_decode       in   1              decode cannot accept the head this cycle
//   flush              in   1              discard all queued and incoming pairs
//   stall_fetch        out  1              buffer full; PC must hold
//   valid_decode       out  1              head entry is a real instruction
//   pc_decode          out  [PC_MAX_B:2]   PC of head entry (0 when empty)
//   instruction_decode out  32             head instruction (NOP_INSTR when empty)
module jzjpcc_fetch_decode_buffer #(
  parameter int          PC_MAX_B  = 31,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetchValid,
  input  logic [PC_MAX_B:2] currentPC_fetch,
  input  logic [31:0]       instruction_fetch,
  input  logic              stall_decode,
  input  logic              flush,
  output logic              stall_fetch,
  output logic              valid_decode,
  output logic [PC_MAX_B:2] pc_decode,
  output logic [31:0]       instruction_decode
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = PC_MAX_B - 1;

  // Entry storage is deliberately not reset; count gates every read.
  logic [PC_MAX_B:2] pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic [CNT_W-1:0] count_next_s;

  // Status decode and handshake qualification.
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    // Full stalls even when the head pops this cycle: keeps stall_decode off the PC path.
    push_s  = fetchValid & ~full_s & ~flush;
    pop_s   = ~empty_s & ~stall_decode & ~flush;
  end

  // Occupancy update; simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and count registers; reset and flush both empty the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Entry write port; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      pc_mem[wr_ptr_r]    <= currentPC_fetch;
      instr_mem[wr_ptr_r] <= instruction_fetch;
    end
  end

  // Decode-facing outputs, combinational from registered state only.
  always_comb begin
    stall_fetch  = full_s;
    valid_decode = ~empty_s;
    if (!empty_s) begin
      pc_decode          = pc_mem[rd_ptr_r];
      instruction_decode = instr_mem[rd_ptr_r];
    end else begin
      pc_decode          = {PC_W{1'b0}};
      instruction_decode = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_jzjpcc_fetch_decode_buffer.sv
// Directed testbench for jzjpcc_fetch_decode_buffer (DEPTH=2, PC_MAX_B=31).
module tb_jzjpcc_fetch_decode_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock;
  logic        reset;
  logic        fetchValid;
  logic [31:2] currentPC_fetch;
  logic [31:0] instruction_fetch;
  logic        stall_decode;
  logic        flush;
  logic        stall_fetch;
  logic        valid_decode;
  logic [31:2] pc_decode;
  logic [31:0] instruction_decode;

  int checks;
  int failures;

  jzjpcc_fetch_decode_buffer #(
    .PC_MAX_B (31),
    .DEPTH    (2),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .fetchValid        (fetchValid),
    .currentPC_fetch   (currentPC_fetch),
    .instruction_fetch (instruction_fetch),
    .stall_decode      (stall_decode),
    .flush             (flush),
    .stall_fetch       (stall_fetch),
    .valid_decode      (valid_decode),
    .pc_decode         (pc_decode),
    .instruction_decode(instruction_decode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    fetchValid        = v;
    currentPC_fetch   = pc[29:0];
    instruction_fetch = ins;
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic st);
    check({tag, ".valid"}, {31'd0, valid_decode}, {31'd0, v});
    check({tag, ".pc"},    {2'd0, pc_decode}, pc);
    check({tag, ".instr"}, instruction_decode, ins);
    check({tag, ".stall"}, {31'd0, stall_fetch}, {31'd0, st});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    flush = 1'b0;
    stall_decode = 1'b0;
    present(1'b0, 32'd0, 32'd0);

    // 1: reset held two cycles
    cycle();
    cycle();
    reset = 1'b0;
    expect_head("reset", 1'b0, 32'd0, NOP, 1'b0);

    // 2: streaming, each pair visible one cycle after push
    present(1'b1, 32'd0, 32'hAAAA0000);
    cycle();
    expect_head("stream0", 1'b1, 32'd0, 32'hAAAA0000, 1'b0);
    present(1'b1, 32'd1, 32'hBBBB0001);
    cycle();
    expect_head("stream1", 1'b1, 32'd1, 32'hBBBB0001, 1'b0);
    present(1'b1, 32'd2, 32'hCCCC0002);
    cycle();
    expect_head("stream2", 1'b1, 32'd2, 32'hCCCC0002, 1'b0);
    present(1'b1, 32'd3, 32'hDDDD0003);
    cycle();
    expect_head("stream3", 1'b1, 32'd3, 32'hDDDD0003, 1'b0);
    present(1'b0, 32'd0, 32'd0);
    cycle();
    expect_head("stream_drain", 1'b0, 32'd0, NOP, 1'b0);

    // 3: back-pressure
    stall_decode = 1'b1;
    present(1'b1, 32'd0, 32'hAAAA0000);
    cycle();
    expect_head("bp_push0", 1'b1, 32'd0, 32'hAAAA0000, 1'b0);
    present(1'b1, 32'd1, 32'hBBBB0001);
    cycle();
    expect_head("bp_full", 1'b1, 32'd0, 32'hAAAA0000, 1'b1);
    present(1'b1, 32'd2, 32'hCCCC0002);
    cycle();
    expect_head("bp_hold", 1'b1, 32'd0, 32'hAAAA0000, 1'b1);
    stall_decode = 1'b0;
    cycle();
    expect_head("bp_drain1", 1'b1, 32'd1, 32'hBBBB0001, 1'b0);
    cycle();
    expect_head("bp_resume", 1'b1, 32'd2, 32'hCCCC0002, 1'b0);
    present(1'b0, 32'd0, 32'd0);
    cycle();
    expect_head("bp_empty", 1'b0, 32'd0, NOP, 1'b0);

    // 4: flush with two queued entries and an incoming pair
    stall_decode = 1'b1;
    present(1'b1, 32'd5, 32'hEEEE0005);
    cycle();
    present(1'b1, 32'd6, 32'hFFFF0006);
    cycle();
    expect_head("fl_full", 1'b1, 32'd5, 32'hEEEE0005, 1'b1);
    flush = 1'b1;
    present(1'b1, 32'd7, 32'h77770007);
    cycle();
    expect_head("fl_after", 1'b0, 32'd0, NOP, 1'b0);
    flush = 1'b0;
    stall_decode = 1'b0;
    present(1'b0, 32'd0, 32'd0);
    cycle();
    expect_head("fl_dropped", 1'b0, 32'd0, NOP, 1'b0);

    // 5: push+pop at count=1 for 8 cycles, pointers wrap
    present(1'b1, 32'd8, 32'h50000008);
    cycle();
    expect_head("pp_first", 1'b1, 32'd8, 32'h50000008, 1'b0);
    for (int i = 0; i < 8; i++) begin
      present(1'b1, 32'd9 + 32'(i), 32'h50000009 + 32'(i));
      cycle();
      expect_head($sformatf("pp%0d", i), 1'b1, 32'd9 + 32'(i), 32'h50000009 + 32'(i), 1'b0);
    end
    present(1'b0, 32'd0, 32'd0);
    cycle();
    expect_head("pp_empty", 1'b0, 32'd0, NOP, 1'b0);

    // 6: reset while full and stalled
    stall_decode = 1'b1;
    present(1'b1, 32'd20, 32'h20202020);
    cycle();
    present(1'b1, 32'd21, 32'h21212121);
    cycle();
    expect_head("rs_full", 1'b1, 32'd20, 32'h20202020, 1'b1);
    reset = 1'b1;
    cycle();
    expect_head("rs_after", 1'b0, 32'd0, NOP, 1'b0);
    reset = 1'b0;
    present(1'b0, 32'd0, 32'd0);
    cycle();
    expect_head("rs_idle", 1'b0, 32'd0, NOP, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
